// File: rtl/md_sequencer.sv
// Multiply/divide sequencer for the EX stage: owns HI/LO, models multi-cycle
// MULT/DIV latency with a down-counter and raises the D-stage stall request.
module md_sequencer #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        d_uses_md,
    output logic        busy,
    output logic        stall,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t            state_r, state_s;
    logic [CNT_W-1:0]  cnt_r, cnt_s;
    logic [2:0]        op_r, op_s;
    logic [31:0]       a_r, a_s;
    logic [31:0]       b_r, b_s;
    logic [31:0]       hi_r, hi_s;
    logic [31:0]       lo_r, lo_s;
    logic              busy_r, busy_s;
    logic              is_md_s;
    logic [63:0]       result_s;

    function automatic logic [31:0] mag32(input logic [31:0] v);
        logic [31:0] m;
        m = v[31] ? (32'd0 - v) : v;
        return m;
    endfunction

    // Returns {hi,lo}; a zero divisor hands back the previous HI/LO unchanged.
    function automatic logic [63:0] md_result(
        input logic [2:0]  op,
        input logic [31:0] x,
        input logic [31:0] y,
        input logic [63:0] prev
    );
        logic [63:0] res;
        logic [31:0] xm;
        logic [31:0] ym;
        logic [31:0] q;
        logic [31:0] r;
        res = prev;
        xm  = 32'd0;
        ym  = 32'd0;
        q   = 32'd0;
        r   = 32'd0;
        case (op)
            OP_MULT: begin
                res = {{32{x[31]}}, x} * {{32{y[31]}}, y};
            end
            OP_MULTU: begin
                res = {32'd0, x} * {32'd0, y};
            end
            OP_DIV: begin
                if (y != 32'd0) begin
                    xm = mag32(x);
                    ym = mag32(y);
                    q  = xm / ym;
                    r  = xm % ym;
                    if (x[31] ^ y[31]) begin
                        q = 32'd0 - q;
                    end else begin
                        q = q;
                    end
                    if (x[31]) begin
                        r = 32'd0 - r;
                    end else begin
                        r = r;
                    end
                    res = {r, q};
                end else begin
                    res = prev;
                end
            end
            OP_DIVU: begin
                if (y != 32'd0) begin
                    res = {x % y, x / y};
                end else begin
                    res = prev;
                end
            end
            default: begin
                res = prev;
            end
        endcase
        return res;
    endfunction

    assign is_md_s  = (md_op >= OP_MULT) && (md_op <= OP_DIVU);
    assign result_s = md_result(op_r, a_r, b_r, {hi_r, lo_r});

    // Next-state logic: accept work in IDLE, count down in BUSY, commit HI/LO at the end.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        op_s    = op_r;
        a_s     = a_r;
        b_s     = b_r;
        hi_s    = hi_r;
        lo_s    = lo_r;
        busy_s  = busy_r;
        case (state_r)
            ST_IDLE: begin
                busy_s = 1'b0;
                if (start) begin
                    case (md_op)
                        OP_MULT, OP_MULTU: begin
                            op_s    = md_op;
                            a_s     = a;
                            b_s     = b;
                            cnt_s   = MULT_LOAD;
                            state_s = ST_BUSY;
                            busy_s  = 1'b1;
                        end
                        OP_DIV, OP_DIVU: begin
                            op_s    = md_op;
                            a_s     = a;
                            b_s     = b;
                            cnt_s   = DIV_LOAD;
                            state_s = ST_BUSY;
                            busy_s  = 1'b1;
                        end
                        OP_MTHI: begin
                            hi_s = a;
                        end
                        OP_MTLO: begin
                            lo_s = a;
                        end
                        default: begin
                            state_s = ST_IDLE;
                        end
                    endcase
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_BUSY: begin
                // Any start seen here is dropped so the in-flight result stays intact.
                busy_s = 1'b1;
                if (cnt_r <= {{(CNT_W-1){1'b0}}, 1'b1}) begin
                    cnt_s   = {CNT_W{1'b0}};
                    state_s = ST_IDLE;
                    busy_s  = 1'b0;
                    hi_s    = result_s[63:32];
                    lo_s    = result_s[31:0];
                end else begin
                    cnt_s = cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = {CNT_W{1'b0}};
                busy_s  = 1'b0;
            end
        endcase
    end

    // State and HI/LO registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
            cnt_r   <= {CNT_W{1'b0}};
            op_r    <= 3'd0;
            a_r     <= 32'd0;
            b_r     <= 32'd0;
            hi_r    <= 32'd0;
            lo_r    <= 32'd0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            op_r    <= op_s;
            a_r     <= a_s;
            b_r     <= b_s;
            hi_r    <= hi_s;
            lo_r    <= lo_s;
            busy_r  <= busy_s;
        end
    end

    assign busy  = busy_r;
    assign hi    = hi_r;
    assign lo    = lo_r;
    assign stall = d_uses_md & (busy_r | (start & is_md_s));

endmodule

// File: tb/tb_md_sequencer.sv
// Directed plus randomized bench for md_sequencer, checked against an
// arithmetic reference model of HI/LO and the busy/stall timing.
module tb_md_sequencer;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  md_op;
    logic [31:0] a;
    logic [31:0] b;
    logic        d_uses_md;
    logic        busy;
    logic        stall;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks;
    int failures;
    logic [31:0] m_hi;
    logic [31:0] m_lo;

    md_sequencer #(.MULT_CYCLES(5), .DIV_CYCLES(10), .CNT_W(4)) dut (
        .clk(clk), .reset(reset), .start(start), .md_op(md_op), .a(a), .b(b),
        .d_uses_md(d_uses_md), .busy(busy), .stall(stall), .hi(hi), .lo(lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: {hi,lo} from plain 64-bit arithmetic on the operands.
    function automatic logic [63:0] ref_md(input logic [2:0] op, input logic [31:0] x,
                                           input logic [31:0] y, input logic [63:0] prev);
        longint          sx, sy, p, q, r;
        longint unsigned ux, uy, up;
        sx = $signed(x);
        sy = $signed(y);
        ux = x;
        uy = y;
        case (op)
            3'd1: begin p = sx * sy; return p; end
            3'd2: begin up = ux * uy; return up; end
            3'd3: begin
                if (y == 32'd0) return prev;
                q = sx / sy;
                r = sx % sy;
                return {r[31:0], q[31:0]};
            end
            3'd4: begin
                if (y == 32'd0) return prev;
                return {32'(ux % uy), 32'(ux / uy)};
            end
            default: return prev;
        endcase
    endfunction

    task automatic do_op(input logic [2:0] op, input logic [31:0] av, input logic [31:0] bv,
                         input logic du, input logic inj);
        logic [63:0] nxt;
        int n;
        logic is_md;
        is_md = (op >= 3'd1) && (op <= 3'd4);
        n = (op <= 3'd2) ? 5 : 10;
        start = 1'b1; md_op = op; a = av; b = bv; d_uses_md = du;
        #1;
        chk("stall_accept", {31'd0, stall}, {31'd0, du & is_md});
        tick();
        start = 1'b0; md_op = 3'd0; a = $urandom; b = $urandom;
        if (is_md) begin
            nxt = ref_md(op, av, bv, {m_hi, m_lo});
            for (int k = 0; k < n; k++) begin
                #1;
                chk("busy_hold", {31'd0, busy}, 32'd1);
                chk("stall_busy", {31'd0, stall}, {31'd0, du});
                chk("hi_old", hi, m_hi);
                chk("lo_old", lo, m_lo);
                if (inj && k == 2) begin
                    start = 1'b1; md_op = 3'd6; a = 32'h0000_1234;
                end else begin
                    start = 1'b0; md_op = 3'd0;
                end
                tick();
            end
            start = 1'b0; md_op = 3'd0;
            m_hi = nxt[63:32];
            m_lo = nxt[31:0];
            #1;
            chk("stall_done", {31'd0, stall}, 32'd0);
        end else begin
            if (op == 3'd5) m_hi = av;
            else if (op == 3'd6) m_lo = av;
        end
        chk("busy_idle", {31'd0, busy}, 32'd0);
        chk("hi", hi, m_hi);
        chk("lo", lo, m_lo);
    endtask

    initial begin
        checks = 0; failures = 0;
        m_hi = 32'd0; m_lo = 32'd0;
        reset = 1'b1; start = 1'b0; md_op = 3'd0; a = 32'd0; b = 32'd0; d_uses_md = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);

        do_op(3'd1, 32'hFFFF_FFFE, 32'd3, 1'b0, 1'b0);
        chk("mult_hi", hi, 32'hFFFF_FFFF);
        chk("mult_lo", lo, 32'hFFFF_FFFA);
        do_op(3'd2, 32'hFFFF_FFFF, 32'd2, 1'b0, 1'b0);
        chk("multu_hi", hi, 32'h0000_0001);
        chk("multu_lo", lo, 32'hFFFF_FFFE);
        do_op(3'd3, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
        chk("div_hi", hi, 32'hFFFF_FFFF);
        chk("div_lo", lo, 32'hFFFF_FFFD);
        do_op(3'd4, 32'd7, 32'd0, 1'b0, 1'b0);
        chk("divz_hi", hi, 32'hFFFF_FFFF);
        chk("divz_lo", lo, 32'hFFFF_FFFD);
        do_op(3'd1, 32'd1000, 32'd77, 1'b1, 1'b1);
        chk("inj_lo", lo, 32'd77000);
        do_op(3'd5, 32'hDEAD_BEEF, 32'd0, 1'b1, 1'b0);
        chk("mthi", hi, 32'hDEAD_BEEF);
        do_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
        chk("ovf_hi", hi, 32'd0);
        chk("ovf_lo", lo, 32'h8000_0000);
        do_op(3'd0, 32'h1111_1111, 32'd5, 1'b1, 1'b0);
        do_op(3'd7, 32'h2222_2222, 32'd5, 1'b1, 1'b0);

        // Reset three cycles into a divide discards the pending result.
        start = 1'b1; md_op = 3'd3; a = 32'd100; b = 32'd7;
        tick();
        start = 1'b0; md_op = 3'd0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        m_hi = 32'd0; m_lo = 32'd0;
        chk("rstmid_busy", {31'd0, busy}, 32'd0);
        chk("rstmid_hi", hi, 32'd0);
        chk("rstmid_lo", lo, 32'd0);
        for (int k = 0; k < 12; k++) begin
            tick();
            chk("rstmid_quiet_hi", hi, 32'd0);
            chk("rstmid_quiet_lo", lo, 32'd0);
            chk("rstmid_quiet_busy", {31'd0, busy}, 32'd0);
        end

        for (int i = 0; i < 40; i++) begin
            logic [2:0]  rop;
            logic [31:0] ra, rb;
            rop = 3'($urandom_range(0, 7));
            ra  = $urandom;
            case ($urandom_range(0, 3))
                0: rb = 32'd0;
                1: rb = 32'($urandom_range(1, 20));
                2: rb = 32'hFFFF_FFFF - 32'($urandom_range(0, 5));
                default: rb = $urandom;
            endcase
            do_op(rop, ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/md_sequencer.md
Name: md_sequencer

Overview:
- Multiply/divide sequencer for the pipelined MIPS CPU; sits beside the ALU in the EX stage.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from EX and models multi-cycle latency with a busy counter.
- Owns the HI/LO registers.
- Produces the stall request the hazard logic uses to freeze the D stage while an MD result is pending.

Parameters:
- MULT_CYCLES, 5, cycles from accepted multiply to HI/LO update (>=1)
- DIV_CYCLES, 10, cycles from accepted divide to HI/LO update (>=1)
- CNT_W, 4, counter width; must hold max(MULT_CYCLES, DIV_CYCLES)

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  EX-stage MD instruction valid this cycle
- md_op  input  3  0 none, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved (no-op)
- a  input  32  rs operand (forwarded)
- b  input  32  rt operand (forwarded)
- d_uses_md  input  1  D-stage instruction is MULT/MULTU/DIV/DIVU/MFHI/MFLO/MTHI/MTLO
- busy  output  1  operation in flight
- stall  output  1  D-stage stall request
- hi  output  32  HI register
- lo  output  32  LO register

Behaviour:
- One clock; reset is synchronous and active-high, sampled on the rising edge of clk.
- Reset (including mid-operation): state IDLE, counter 0, busy 0, hi 0, lo 0; any in-flight result is discarded.
- States:
  - IDLE: busy=0.
  - BUSY: busy=1.
- IDLE, start=1, md_op in 1..4:
  - Operands are latched and the full result is computed from the latched values.
  - Counter loads MULT_CYCLES (ops 1,2) or DIV_CYCLES (ops 3,4); go to BUSY.
- IDLE, start=1, md_op 5 or 6: hi<=a or lo<=a at that edge; remain IDLE; busy stays 0.
- IDLE, start=1, md_op 0 or 7: no effect.
- BUSY:
  - Counter decrements each edge.
  - At the edge where counter==1: hi/lo update, counter goes to 0, state goes to IDLE, busy falls.
  - Consequence: busy is high for exactly N cycles after the accepting edge, and the new hi/lo are visible in the same cycle busy is first 0.
- Results:
  - MULT: {hi,lo} = signed 32x32 -> 64-bit product.
  - MULTU: {hi,lo} = unsigned 32x32 -> 64-bit product.
  - DIV: lo = signed quotient truncated toward zero; hi = remainder with the sign of the dividend.
  - DIVU: unsigned quotient and remainder.
  - Divide by zero (b==0): hi/lo keep previous values; full DIV_CYCLES busy time still applies.
  - DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
- start=1 while BUSY: ignored entirely, including MTHI/MTLO. The hazard unit guarantees this cannot occur; the sequencer must not corrupt the in-flight result.
- stall = d_uses_md & (busy | (start & md_op in 1..4)). Purely combinational.
- Plain MFHI/MFLO reads during BUSY see the old hi/lo; stall prevents this in the pipeline.
- hi/lo written only at the points above; no other outputs change.

Test Plan:
- Reset, then MULT a=0xFFFFFFFE(-2) b=3 -> busy=1 for 5 cycles; after the 5th edge hi=0xFFFFFFFF, lo=0xFFFFFFFA, busy=0.
- MULTU a=0xFFFFFFFF b=2 -> after 5 cycles hi=0x00000001, lo=0xFFFFFFFE.
- DIV a=0xFFFFFFF9(-7) b=2 -> busy 10 cycles; lo=0xFFFFFFFD(-3), hi=0xFFFFFFFF(-1). Then DIVU a=7 b=0 -> hi/lo unchanged, busy still 10 cycles.
- MULT accepted with d_uses_md=1 in the same cycle -> stall=1 that cycle and for all 5 busy cycles, then 0. Second start (MTLO a=0x1234) during busy -> ignored; lo equals the product.
- MTHI a=0xDEADBEEF in IDLE -> hi=0xDEADBEEF next cycle, busy stays 0. DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- Reset asserted 3 cycles into a DIV -> next edge busy=0, hi=lo=0; no later HI/LO update occurs.
